// File: rtl/fp32_pkg.sv
// Shared single-precision field widths, the packed operand layout and small
// exponent helpers used across the FP adder datapath.
package fp32_pkg;

  localparam int EXP_W    = 8;
  localparam int FRAC_W   = 23;
  localparam int MAN_W    = 24;
  localparam int ALIGN_W  = 27;
  localparam int EXP_BIAS = 127;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [FRAC_W-1:0] frac;
  } fp32_t;

  // Denormals carry no hidden bit and share the exponent of the smallest normal.
  function automatic logic hidden_bit(input logic [EXP_W-1:0] exp);
    return (exp != '0);
  endfunction

  function automatic logic [EXP_W-1:0] eff_exp(input logic [EXP_W-1:0] exp);
    return (exp == '0) ? EXP_W'(1) : exp;
  endfunction

endpackage

// File: rtl/rshift_sticky27.sv
// Combinational 27-bit right shifter; every bit shifted out is OR'd into bit 0
// so the LSB acts as the sticky bit of the aligned mantissa.
module rshift_sticky27
  import fp32_pkg::*;
(
  input  logic [ALIGN_W-1:0] din,
  input  logic [EXP_W-1:0]   shamt,
  output logic [ALIGN_W-1:0] dout
);

  logic [ALIGN_W-1:0] v;
  logic               lost;

  // Five log stages (1,2,4,8,16); each folds its discarded bits into the LSB.
  always_comb begin
    v    = din;
    lost = 1'b0;
    for (int k = 0; k < 5; k++) begin
      if (shamt[k]) begin
        lost = |(v & ((ALIGN_W'(1) << (1 << k)) - ALIGN_W'(1)));
        v    = v >> (1 << k);
        v[0] = v[0] | lost;
      end
    end
    if (shamt >= EXP_W'(ALIGN_W)) begin
      dout = {{(ALIGN_W-1){1'b0}}, |din};
    end else begin
      dout = v;
    end
  end

endmodule

// File: rtl/fp_align_stage.sv
// FP adder mantissa alignment: orders operands by exponent, restores hidden
// bits and right-shifts the smaller mantissa with guard/round/sticky.
module fp_align_stage
  import fp32_pkg::*;
#(
  parameter real T = 0.0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                a_sign,
  input  logic [EXP_W-1:0]    a_exp,
  input  logic [FRAC_W-1:0]   a_man,
  input  logic                b_sign,
  input  logic [EXP_W-1:0]    b_exp,
  input  logic [FRAC_W-1:0]   b_man,
  input  logic                a_lt_b,
  input  logic                a_eq_b,
  input  logic                a_gt_b,
  input  logic [EXP_W-1:0]    abs_diff,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                big_sign,
  output logic                small_sign,
  output logic [EXP_W-1:0]    big_exp,
  output logic [ALIGN_W-1:0]  big_man,
  output logic [ALIGN_W-1:0]  small_man,
  output logic                swapped
);

  // T only models assign delay in behavioural views; this RTL is zero-delay.
  if (T < 0.0) begin : g_neg_delay
  end

  fp32_t            op_a, op_b, big_op, small_op;
  logic             swap_c;
  logic [EXP_W-1:0] shamt_c;

  logic             vld_p1, vld_p2, load_p1, load_p2;
  logic             sign_big_p1, sign_small_p1, swap_p1;
  logic [EXP_W-1:0] exp_big_p1, shamt_p1;
  logic [MAN_W-1:0] man_big_p1, man_small_p1;
  logic [ALIGN_W-1:0] shifted_p1;

  assign load_p2   = ~vld_p2 | out_ready;
  assign load_p1   = ~vld_p1 | load_p2;
  assign in_ready  = load_p1;
  assign out_valid = vld_p2;

  assign op_a = {a_sign, a_exp, a_man};
  assign op_b = {b_sign, b_exp, b_man};

  // Flags are one-hot; the extra terms only make A win if they ever disagree.
  assign swap_c = a_lt_b & ~(a_eq_b | a_gt_b);

  always_comb begin
    big_op   = op_a;
    small_op = op_b;
    if (swap_c) begin
      big_op   = op_b;
      small_op = op_a;
    end
    if (a_exp == '0 && b_exp == '0) begin
      shamt_c = '0;
    end else if (a_exp == '0 || b_exp == '0) begin
      shamt_c = abs_diff - EXP_W'(1);
    end else begin
      shamt_c = abs_diff;
    end
  end

  // ---- stage 1: swap / hidden-bit restore ----
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1        <= 1'b0;
      sign_big_p1   <= 1'b0;
      sign_small_p1 <= 1'b0;
      swap_p1       <= 1'b0;
      exp_big_p1    <= '0;
      shamt_p1      <= '0;
      man_big_p1    <= '0;
      man_small_p1  <= '0;
    end else if (load_p1) begin
      vld_p1 <= in_valid;
      if (in_valid) begin
        sign_big_p1   <= big_op.sign;
        sign_small_p1 <= small_op.sign;
        swap_p1       <= swap_c;
        exp_big_p1    <= eff_exp(big_op.exp);
        shamt_p1      <= shamt_c;
        man_big_p1    <= {hidden_bit(big_op.exp), big_op.frac};
        man_small_p1  <= {hidden_bit(small_op.exp), small_op.frac};
      end
    end
  end

  rshift_sticky27 u_shift (
    .din   ({man_small_p1, 3'b000}),
    .shamt (shamt_p1),
    .dout  (shifted_p1)
  );

  // ---- stage 2: alignment shift ----
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p2     <= 1'b0;
      big_sign   <= 1'b0;
      small_sign <= 1'b0;
      swapped    <= 1'b0;
      big_exp    <= '0;
      big_man    <= '0;
      small_man  <= '0;
    end else if (load_p2) begin
      vld_p2 <= vld_p1;
      if (vld_p1) begin
        big_sign   <= sign_big_p1;
        small_sign <= sign_small_p1;
        swapped    <= swap_p1;
        big_exp    <= exp_big_p1;
        big_man    <= {man_big_p1, 3'b000};
        small_man  <= shifted_p1;
      end
    end
  end

endmodule

// File: tb/tb_fp_align_stage.sv
// Directed bench for fp_align_stage: vector table plus backpressure and
// mid-flight reset sequences.
module tb_fp_align_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic        a_sign, b_sign;
  logic [7:0]  a_exp, b_exp, abs_diff;
  logic [22:0] a_man, b_man;
  logic        a_lt_b, a_eq_b, a_gt_b;
  logic        out_valid, out_ready;
  logic        big_sign, small_sign, swapped;
  logic [7:0]  big_exp;
  logic [26:0] big_man, small_man;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  assign a_lt_b = (a_exp < b_exp);
  assign a_eq_b = (a_exp == b_exp);
  assign a_gt_b = (a_exp > b_exp);

  always @(posedge clk)
    if (in_valid && !rst)
      assert ($onehot({a_lt_b, a_eq_b, a_gt_b})) else $error("comparator flags not one-hot");

  fp_align_stage #(.T(0.0)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a_sign(a_sign), .a_exp(a_exp), .a_man(a_man),
    .b_sign(b_sign), .b_exp(b_exp), .b_man(b_man),
    .a_lt_b(a_lt_b), .a_eq_b(a_eq_b), .a_gt_b(a_gt_b), .abs_diff(abs_diff),
    .out_valid(out_valid), .out_ready(out_ready),
    .big_sign(big_sign), .small_sign(small_sign), .big_exp(big_exp),
    .big_man(big_man), .small_man(small_man), .swapped(swapped)
  );

  typedef struct {
    logic        asg;
    logic [7:0]  aex;
    logic [22:0] afr;
    logic        bsg;
    logic [7:0]  bex;
    logic [22:0] bfr;
    logic        e_sw;
    logic        e_bs;
    logic        e_ss;
    logic [7:0]  e_bexp;
    logic [26:0] e_bman;
    logic [26:0] e_sman;
  } vec_t;

  localparam int NV = 11;
  vec_t vecs [NV];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  task automatic drive(input int i);
    a_sign   = vecs[i].asg;
    a_exp    = vecs[i].aex;
    a_man    = vecs[i].afr;
    b_sign   = vecs[i].bsg;
    b_exp    = vecs[i].bex;
    b_man    = vecs[i].bfr;
    abs_diff = (vecs[i].aex > vecs[i].bex) ? vecs[i].aex - vecs[i].bex
                                           : vecs[i].bex - vecs[i].aex;
  endtask

  task automatic check_out(input int i, input string tag);
    chk($sformatf("%s.valid", tag), 32'(out_valid), 32'd1);
    chk($sformatf("%s.swapped", tag), 32'(swapped), 32'(vecs[i].e_sw));
    chk($sformatf("%s.big_sign", tag), 32'(big_sign), 32'(vecs[i].e_bs));
    chk($sformatf("%s.small_sign", tag), 32'(small_sign), 32'(vecs[i].e_ss));
    chk($sformatf("%s.big_exp", tag), 32'(big_exp), 32'(vecs[i].e_bexp));
    chk($sformatf("%s.big_man", tag), 32'(big_man), 32'(vecs[i].e_bman));
    chk($sformatf("%s.small_man", tag), 32'(small_man), 32'(vecs[i].e_sman));
  endtask

  task automatic run_vec(input int i);
    int n;
    drive(i);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 6) begin
      tick();
      n++;
    end
    if (!out_valid) begin
      total++;
      bad++;
      $display("FAIL vec%0d.timeout: got no out_valid want out_valid within 6 cycles", i);
    end else begin
      chk($sformatf("vec%0d.latency", i), 32'(n), 32'd1);
      check_out(i, $sformatf("vec%0d", i));
    end
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want test completion");
    $fatal(1, "watchdog");
  end

  initial begin
    //          asg aex     afr         bsg bex     bfr         sw bs ss bexp    big_man       small_man
    vecs[0]  = '{0, 8'd127, 23'h000000, 0, 8'd127, 23'h000000, 0, 0, 0, 8'd127, 27'h4000000, 27'h4000000};
    vecs[1]  = '{0, 8'd127, 23'h000000, 0, 8'd130, 23'h000000, 1, 0, 0, 8'd130, 27'h4000000, 27'h0800000};
    vecs[2]  = '{0, 8'd150, 23'h000001, 0, 8'd100, 23'h000000, 0, 0, 0, 8'd150, 27'h4000008, 27'h0000001};
    vecs[3]  = '{0, 8'd1,   23'h000000, 0, 8'd0,   23'h400000, 0, 0, 0, 8'd1,   27'h4000000, 27'h2000000};
    vecs[4]  = '{0, 8'd0,   23'h000001, 1, 8'd0,   23'h000002, 0, 0, 1, 8'd1,   27'h0000008, 27'h0000010};
    vecs[5]  = '{1, 8'd10,  23'h7FFFFF, 0, 8'd12,  23'h000000, 1, 0, 1, 8'd12,  27'h4000000, 27'h1FFFFFE};
    vecs[6]  = '{0, 8'd130, 23'h000000, 1, 8'd125, 23'h000003, 0, 0, 1, 8'd130, 27'h4000000, 27'h0200001};
    vecs[7]  = '{0, 8'd200, 23'h000000, 0, 8'd175, 23'h000000, 0, 0, 0, 8'd200, 27'h4000000, 27'h0000002};
    vecs[8]  = '{0, 8'd255, 23'h400000, 0, 8'd100, 23'h000000, 0, 0, 0, 8'd255, 27'h6000000, 27'h0000001};
    vecs[9]  = '{1, 8'd0,   23'h000000, 0, 8'd40,  23'h000000, 1, 0, 1, 8'd40,  27'h4000000, 27'h0000000};
    vecs[10] = '{0, 8'd3,   23'h000000, 0, 8'd0,   23'h7FFFFF, 0, 0, 0, 8'd3,   27'h4000000, 27'h0FFFFFE};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a_sign = 0; a_exp = 0; a_man = 0; b_sign = 0; b_exp = 0; b_man = 0; abs_diff = 0;
    tick();
    tick();
    chk("reset.out_valid", 32'(out_valid), 32'd0);
    chk("reset.big_man", 32'(big_man), 32'd0);
    chk("reset.small_man", 32'(small_man), 32'd0);
    chk("reset.big_exp", 32'(big_exp), 32'd0);
    rst = 1'b0;
    tick();
    chk("reset.in_ready", 32'(in_ready), 32'd1);

    for (int i = 0; i < NV; i++) run_vec(i);

    // Backpressure: three back-to-back offers with the sink stalled.
    out_ready = 1'b0;
    drive(1); in_valid = 1'b1;
    tick();
    chk("bp.in_ready_2nd", 32'(in_ready), 32'd1);
    drive(2);
    tick();
    drive(6);
    chk("bp.in_ready_3rd", 32'(in_ready), 32'd0);
    check_out(1, "bp.held0");
    tick();
    chk("bp.still_blocked", 32'(in_ready), 32'd0);
    check_out(1, "bp.held1");
    out_ready = 1'b1;
    #1;
    chk("bp.in_ready_release", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    check_out(2, "bp.out1");
    tick();
    check_out(6, "bp.out2");
    tick();
    chk("bp.drained", 32'(out_valid), 32'd0);

    // Reset with both stages full discards everything in flight.
    out_ready = 1'b0;
    drive(3); in_valid = 1'b1;
    tick();
    drive(5);
    tick();
    in_valid = 1'b0;
    chk("rst.full", 32'(in_ready), 32'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst.out_valid", 32'(out_valid), 32'd0);
    chk("rst.in_ready", 32'(in_ready), 32'd1);
    chk("rst.big_man", 32'(big_man), 32'd0);
    drive(7); in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("rst.lat1", 32'(out_valid), 32'd0);
    tick();
    check_out(7, "rst.new");
    tick();
    chk("rst.no_dup", 32'(out_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
